// File: rtl/nic_pkg.sv
// Shared constants for the NIC controller: register map, default width
// and status-bit position.
package nic_pkg;

    localparam int NIC_DATA_W = 64;
    localparam int STAT_BIT   = 0;

    localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

endpackage

// File: rtl/nic_chan_buf.sv
// One-entry channel buffer with load, clear and full flag.
// Load and clear are never asserted together by the parent.
module nic_chan_buf #(
    parameter int W = 64
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         full_o
);

    logic [W-1:0] data_q, data_d;
    logic         full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            data_d = data_i;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/nic_ctrl.sv
// NIC controller: processor register window over one-entry rx/tx buffers.
// Define NIC_POLARITY_EN to gate sends on the router virtual-channel phase.
module nic_ctrl
    import nic_pkg::*;
#(
    parameter int DATA_W = NIC_DATA_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    input  logic              net_si,
    input  logic              net_ri,
    input  logic [DATA_W-1:0] net_di,
    output logic              net_so,
    output logic              net_ro,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_polarity
);

    logic [DATA_W-1:0] in_data, out_data;
    logic              in_full, out_full;
    logic              rd_en, wr_en;
    logic              in_load, in_clear;
    logic              out_load, out_clear;
    logic              send_ok;

    assign rd_en = nicEn & ~nicWrEn;
    assign wr_en = nicEn & nicWrEn;

`ifdef NIC_POLARITY_EN
    assign send_ok = (out_data[0] == net_polarity);
`else
    logic unused_polarity;
    assign unused_polarity = net_polarity;
    assign send_ok = 1'b1;
`endif

    assign net_ro = ~in_full;
    assign net_so = out_full & send_ok;
    assign net_do = out_data;

    // Fill is blocked while full, so fill and drain-read never collide.
    assign in_load  = net_si & ~in_full;
    assign in_clear = rd_en & (addr == ADDR_IN_BUF) & in_full;

    // Write decision uses pre-edge out_full, so a write racing a drain drops.
    assign out_load  = wr_en & (addr == ADDR_OUT_BUF) & ~out_full;
    assign out_clear = net_so & net_ri;

    nic_chan_buf #(.W(DATA_W)) u_in_buf (
        .clk_i   (CLK),
        .rst_n_i (RESET),
        .load_i  (in_load),
        .clear_i (in_clear),
        .data_i  (net_di),
        .data_o  (in_data),
        .full_o  (in_full)
    );

    nic_chan_buf #(.W(DATA_W)) u_out_buf (
        .clk_i   (CLK),
        .rst_n_i (RESET),
        .load_i  (out_load),
        .clear_i (out_clear),
        .data_i  (d_in),
        .data_o  (out_data),
        .full_o  (out_full)
    );

    always_comb begin
        d_out = '0;
        if (rd_en) begin
            unique case (addr)
                ADDR_IN_BUF:   d_out = in_data;
                ADDR_IN_STAT:  d_out[STAT_BIT] = in_full;
                ADDR_OUT_BUF:  d_out = out_data;
                ADDR_OUT_STAT: d_out[STAT_BIT] = out_full;
                default:       d_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_nic_ctrl.sv
// Scoreboard bench for nic_ctrl: rx/tx expectations queued at stimulus,
// popped when the DUT delivers the packet.
module tb_nic_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn, nicWrEn;
    logic        net_si, net_ri;
    logic [63:0] net_di;
    logic        net_so, net_ro;
    logic [63:0] net_do;
    logic        net_polarity;

    int total = 0;
    int bad   = 0;

    logic [63:0] rxq[$];
    logic [63:0] txq[$];

    nic_ctrl #(.DATA_W(64)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic rd(input logic [1:0] a, output logic [63:0] v);
        addr = a; nicWrEn = 1'b0; nicEn = 1'b1;
        #1 v = d_out;
        nicEn = 1'b0;
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] v);
        addr = a; d_in = v; nicWrEn = 1'b1; nicEn = 1'b1;
        tick;
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    task automatic test_reset;
        logic [63:0] v;
        RESET = 1'b0;
        tick; tick;
        RESET = 1'b1;
        #1;
        total++; if (net_ro !== 1'b1) begin bad++; $display("FAIL rst_ro got=%b exp=1", net_ro); end
        total++; if (net_so !== 1'b0) begin bad++; $display("FAIL rst_so got=%b exp=0", net_so); end
        total++; if (net_do !== 64'h0) begin bad++; $display("FAIL rst_do got=%h exp=0", net_do); end
        rd(2'b01, v);
        total++; if (v !== 64'h0) begin bad++; $display("FAIL rst_in_stat got=%h exp=0", v); end
        rd(2'b11, v);
        total++; if (v !== 64'h0) begin bad++; $display("FAIL rst_out_stat got=%h exp=0", v); end
        rd(2'b00, v);
        total++; if (v !== 64'h0) begin bad++; $display("FAIL rst_in_data got=%h exp=0", v); end
    endtask

    task automatic test_receive;
        logic [63:0] v, e;
        net_di = 64'hDEAD_BEEF_0000_0001;
        net_si = 1'b1;
        rxq.push_back(net_di);
        tick;
        net_si = 1'b0;
        #1;
        total++; if (net_ro !== 1'b0) begin bad++; $display("FAIL rx_ro_full got=%b exp=0", net_ro); end
        rd(2'b01, v);
        total++; if (v !== 64'h1) begin bad++; $display("FAIL rx_stat_full got=%h exp=1", v); end
        rd(2'b00, v);
        e = rxq.pop_front();
        total++; if (v !== e) begin bad++; $display("FAIL rx_data got=%h exp=%h", v, e); end
        addr = 2'b00; nicWrEn = 1'b0; nicEn = 1'b1;
        tick;
        nicEn = 1'b0;
        #1;
        total++; if (net_ro !== 1'b1) begin bad++; $display("FAIL rx_ro_free got=%b exp=1", net_ro); end
        rd(2'b01, v);
        total++; if (v !== 64'h0) begin bad++; $display("FAIL rx_stat_clr got=%h exp=0", v); end
    endtask

    task automatic test_send;
        logic [63:0] v, e, pk;
        bit got;
        pk = 64'h0000_0000_0000_00A5;
        net_ri = 1'b0;
        net_polarity = pk[0];
        txq.push_back(pk);
        wr(2'b10, pk);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (net_so !== 1'b1) begin bad++; $display("FAIL tx_hold_so[%0d] got=%b exp=1", i, net_so); end
            total++; if (net_do !== pk) begin bad++; $display("FAIL tx_hold_do[%0d] got=%h exp=%h", i, net_do, pk); end
            tick;
        end
        net_ri = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            #1;
            if (net_so === 1'b1) begin
                got = 1'b1;
                e = txq.pop_front();
                total++; if (net_do !== e) begin bad++; $display("FAIL tx_data got=%h exp=%h", net_do, e); end
            end
            tick;
        end
        if (!got) begin total++; bad++; $display("FAIL tx_timeout got=none exp=%h", pk); end
        net_ri = 1'b0;
        #1;
        total++; if (net_so !== 1'b0) begin bad++; $display("FAIL tx_so_clr got=%b exp=0", net_so); end
        rd(2'b11, v);
        total++; if (v !== 64'h0) begin bad++; $display("FAIL tx_stat_clr got=%h exp=0", v); end
    endtask

    task automatic test_overflow;
        logic [63:0] v, e, p1;
        p1 = 64'h1234_5678_9ABC_DEF0;
        net_ri = 1'b0;
        net_polarity = p1[0];
        txq.push_back(p1);
        wr(2'b10, p1);
        wr(2'b10, 64'h1);
        rd(2'b10, v);
        total++; if (v !== p1) begin bad++; $display("FAIL ovf_rd got=%h exp=%h", v, p1); end
        net_ri = 1'b1;
        #1;
        if (net_so === 1'b1) begin
            e = txq.pop_front();
            total++; if (net_do !== e) begin bad++; $display("FAIL ovf_data got=%h exp=%h", net_do, e); end
        end else begin
            total++; bad++; $display("FAIL ovf_so got=%b exp=1", net_so);
        end
        tick;
        net_ri = 1'b0;
        #1;
        total++; if (net_so !== 1'b0) begin bad++; $display("FAIL ovf_second got=%b/%h exp=0", net_so, net_do); end
    endtask

    task automatic test_simultaneous;
        logic [63:0] v, e, p, x;
        p = 64'hCAFE_0000_0000_0010;
        net_ri = 1'b0;
        net_polarity = p[0];
        txq.push_back(p);
        wr(2'b10, p);
        net_ri = 1'b1;
        addr = 2'b10; d_in = 64'h77; nicWrEn = 1'b1; nicEn = 1'b1;
        #1;
        if (net_so === 1'b1) begin
            e = txq.pop_front();
            total++; if (net_do !== e) begin bad++; $display("FAIL sim_drain got=%h exp=%h", net_do, e); end
        end else begin
            total++; bad++; $display("FAIL sim_so got=%b exp=1", net_so);
        end
        tick;
        nicEn = 1'b0; nicWrEn = 1'b0; net_ri = 1'b0;
        #1;
        total++; if (net_so !== 1'b0) begin bad++; $display("FAIL sim_so_clr got=%b exp=0", net_so); end
        rd(2'b11, v);
        total++; if (v !== 64'h0) begin bad++; $display("FAIL sim_out_stat got=%h exp=0", v); end
        rd(2'b10, v);
        total++; if (v !== p) begin bad++; $display("FAIL sim_dropped got=%h exp=%h", v, p); end

        x = 64'h0BAD_F00D_0000_0011;
        net_di = x; net_si = 1'b1;
        rxq.push_back(x);
        tick;
        net_di = 64'hFFFF_FFFF_FFFF_FFFF;
        tick; tick;
        #1;
        total++; if (net_ro !== 1'b0) begin bad++; $display("FAIL sim_ro got=%b exp=0", net_ro); end
        rd(2'b00, v);
        e = rxq.pop_front();
        total++; if (v !== e) begin bad++; $display("FAIL sim_in_hold got=%h exp=%h", v, e); end
        addr = 2'b00; nicWrEn = 1'b0; nicEn = 1'b1;
        tick;
        nicEn = 1'b0; net_si = 1'b0;
        #1;
        total++; if (net_ro !== 1'b1) begin bad++; $display("FAIL sim_fill_block got=%b exp=1", net_ro); end
        rd(2'b00, v);
        total++; if (v !== x) begin bad++; $display("FAIL sim_stale got=%h exp=%h", v, x); end
    endtask

    task automatic test_ignored_writes;
        logic [63:0] v;
        wr(2'b00, 64'h5555);
        wr(2'b01, 64'h1);
        wr(2'b11, 64'h1);
        #1;
        total++; if (net_so !== 1'b0) begin bad++; $display("FAIL ign_so got=%b exp=0", net_so); end
        total++; if (d_out !== 64'h0) begin bad++; $display("FAIL ign_dout_idle got=%h exp=0", d_out); end
        rd(2'b01, v);
        total++; if (v !== 64'h0) begin bad++; $display("FAIL ign_in_stat got=%h exp=0", v); end
        rd(2'b11, v);
        total++; if (v !== 64'h0) begin bad++; $display("FAIL ign_out_stat got=%h exp=0", v); end
        rd(2'b00, v);
        total++; if (v !== 64'h0BAD_F00D_0000_0011) begin bad++; $display("FAIL ign_in_data got=%h exp=0badf00d00000011", v); end
    endtask

    task automatic test_reset_mid;
        logic [63:0] v;
        net_ri = 1'b0;
        net_polarity = 1'b0;
        net_di = 64'h3333; net_si = 1'b1;
        wr(2'b10, 64'h4444);
        net_si = 1'b0;
        net_ri = 1'b1;
        RESET = 1'b0;
        tick;
        RESET = 1'b1; net_ri = 1'b0;
        #1;
        total++; if (net_so !== 1'b0) begin bad++; $display("FAIL rmid_so got=%b exp=0", net_so); end
        total++; if (net_ro !== 1'b1) begin bad++; $display("FAIL rmid_ro got=%b exp=1", net_ro); end
        total++; if (net_do !== 64'h0) begin bad++; $display("FAIL rmid_do got=%h exp=0", net_do); end
        rd(2'b00, v);
        total++; if (v !== 64'h0) begin bad++; $display("FAIL rmid_in got=%h exp=0", v); end
    endtask

`ifdef NIC_POLARITY_EN
    task automatic test_polarity;
        logic [63:0] e;
        net_ri = 1'b0;
        net_polarity = 1'b0;
        txq.push_back(64'h0000_0000_0000_0001);
        wr(2'b10, 64'h0000_0000_0000_0001);
        net_ri = 1'b1;
        #1;
        total++; if (net_so !== 1'b0) begin bad++; $display("FAIL pol_wait got=%b exp=0", net_so); end
        tick;
        net_polarity = 1'b1;
        #1;
        if (net_so === 1'b1) begin
            e = txq.pop_front();
            total++; if (net_do !== e) begin bad++; $display("FAIL pol_data got=%h exp=%h", net_do, e); end
        end else begin
            total++; bad++; $display("FAIL pol_so got=%b exp=1", net_so);
        end
        tick;
        net_ri = 1'b0;
        #1;
        total++; if (net_so !== 1'b0) begin bad++; $display("FAIL pol_drain got=%b exp=0", net_so); end
    endtask
`endif

    initial begin
        RESET = 1'b0; addr = 2'b00; d_in = '0;
        nicEn = 1'b0; nicWrEn = 1'b0;
        net_si = 1'b0; net_ri = 1'b0; net_di = '0;
        net_polarity = 1'b0;
        @(negedge CLK);
        test_reset;
        test_receive;
        test_send;
        test_overflow;
        test_simultaneous;
        test_ignored_writes;
        test_reset_mid;
`ifdef NIC_POLARITY_EN
        test_polarity;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
